// File: rtl/data_unpack_pkg.sv
// data_unpack_pkg: shared FSM encoding and nibble/byte widths for the nibble unpacker.
package data_unpack_pkg;
  localparam int NIB_W  = 4;
  localparam int BYTE_W = 8;
  typedef enum logic {ST_IDLE, ST_RUN} state_e;
endpackage

// File: rtl/data_unpack.sv
// data_unpack: re-emits nibble-length segments of a packed byte stream as whole bytes plus an optional trailing nibble.
module data_unpack
  import data_unpack_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              seg_valid,
  input  logic [LEN_W-1:0]  seg_len,
  output logic              seg_ready,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  output logic [BYTE_W-1:0] data_o,
  output logic              byte_en,
  output logic              data_en,
  output logic              seg_done
);
  state_e             state_q;
  logic [LEN_W-1:0]   rem_q;
  logic [NIB_W-1:0]   res_q;
  logic               res_vld_q;
  logic [BYTE_W-1:0]  data_q;
  logic               byte_en_q, data_en_q, seg_done_q;
  logic               run, two, need_byte, fire;
  logic [BYTE_W-1:0]  beat;
  logic [NIB_W-1:0]   res_d;
  logic               res_vld_d;
  logic [LEN_W-1:0]   rem_d;
  assign run       = state_q == ST_RUN;
  assign two       = |rem_q[LEN_W-1:1];
  assign need_byte = two | ~res_vld_q;
  assign seg_ready = ~run & start;
  assign in_ready  = run & start & in_valid & need_byte;
  assign fire      = run & start & (in_valid | ~need_byte);
  assign beat      = two ? (res_vld_q ? {res_q, in_data[7:4]} : in_data)
                         : {4'h0, res_vld_q ? res_q : in_data[7:4]};
  // A fresh low nibble is captured whenever the beat splits a byte.
  assign res_d     = (two == res_vld_q) ? in_data[3:0] : res_q;
  assign res_vld_d = two ? res_vld_q : ~res_vld_q;
  assign rem_d     = rem_q - (two ? LEN_W'(2) : LEN_W'(1));
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      rem_q      <= '0;
      res_q      <= '0;
      res_vld_q  <= 1'b0;
      data_q     <= '0;
      byte_en_q  <= 1'b0;
      data_en_q  <= 1'b0;
      seg_done_q <= 1'b0;
    end else if (!start) begin
      state_q    <= ST_IDLE;
      rem_q      <= '0;
      res_q      <= '0;
      res_vld_q  <= 1'b0;
      data_en_q  <= 1'b0;
      seg_done_q <= 1'b0;
    end else begin
      data_en_q  <= fire;
      seg_done_q <= 1'b0;
      if (run) begin
        if (fire) begin
          data_q    <= beat;
          byte_en_q <= two;
          rem_q     <= rem_d;
          res_q     <= res_d;
          res_vld_q <= res_vld_d;
          if (rem_d == '0) begin
            seg_done_q <= 1'b1;
            state_q    <= ST_IDLE;
          end
        end
      end else if (seg_valid) begin
        // Zero-length descriptors complete immediately without a data beat.
        if (seg_len == '0) begin
          seg_done_q <= 1'b1;
        end else begin
          rem_q   <= seg_len;
          state_q <= ST_RUN;
        end
      end
    end
  end
  assign data_o   = data_q;
  assign byte_en  = byte_en_q;
  assign data_en  = data_en_q;
  assign seg_done = seg_done_q;
endmodule
